key_event_fifo: RTL
===================

Name: key_event_fifo

Overview:
- Downstream consumer of the 10-key priority encoder outputs: L[3:0] (8421 BCD digit) and GS (key-pressed flag, active-high).
- Synchronises and debounces the raw encoder outputs, turns each debounced key press into a single event, and queues the digits in a small first-word-fall-through FIFO.
- Downstream logic drains the FIFO through a valid/ready handshake; this stage feeds display and entry logic.

Parameters:
DEB_CYCLES, 4, consecutive identical synchronised samples of {GS,L} required before the value is accepted as stable (>=2).
FIFO_DEPTH, 4, FIFO entries; power of two.
AW, 2, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active-low
L  input  4  BCD key code from encoder, asynchronous to clk
GS  input  1  key-pressed flag from encoder, asynchronous to clk
key_ready  input  1  consumer ready to take key_code
clr_ovf  input  1  clears sticky overflow flag
key_valid  output  1  FIFO non-empty; key_code is valid
key_code  output  4  digit at FIFO head (0-9)
fifo_count  output  AW+1  entries currently held, 0..FIFO_DEPTH
overflow  output  1  sticky: a press event was dropped because the FIFO was full

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (rst_n). All registers clear on reset: key_valid=0, key_code=0, fifo_count=0, overflow=0, sync/debounce/stable state=0, FSM=IDLE, FIFO pointers=0.
- Synchroniser: {GS,L} passes through 2 flip-flop stages to produce v[4:0].
- Debounce: registers cand[4:0] and cnt (saturating at DEB_CYCLES).
  - If v!=cand: cand<=v and cnt<=0.
  - Else if cnt==DEB_CYCLES-1: stable<=cand and cnt<=DEB_CYCLES.
  - Else if cnt<DEB_CYCLES-1: cnt<=cnt+1.
  - Any bounce shorter than DEB_CYCLES samples leaves stable unchanged.
- FSM (states IDLE, HELD), driven by stable_gs and stable_code:
  - IDLE, stable_gs=1: generate one press event with stable_code, then go to HELD.
  - HELD, stable_gs=0: go to IDLE.
  - HELD, stable_code changes while stable_gs stays 1 (second key added): no event.
  - Press event with stable_code>9: no push; the FSM still enters HELD.
- Latency: counting the first clk edge that samples the new {GS,L} as edge 1, stable updates on edge DEB_CYCLES+3, the push occurs on edge DEB_CYCLES+4, and key_valid is high after that edge (edge 8 for the default DEB_CYCLES=4).
- FIFO is first-word-fall-through:
  - key_code=mem[rd_ptr]; key_valid=(fifo_count!=0), driven from registered state.
  - Pop when key_valid&&key_ready. Push on a press event.
  - Pointers are AW bits and wrap modulo FIFO_DEPTH.
- FIFO boundary conditions:
  - Empty, push only: key_valid=1 after the edge; a same-cycle pop is impossible.
  - Full, push without pop: entry dropped, overflow<=1, contents unchanged.
  - Full, push and pop in the same cycle: both take effect, fifo_count stays FIFO_DEPTH, no overflow.
  - Not full, push and pop in the same cycle: fifo_count unchanged.
  - key_ready while empty: no effect.
- Overflow flag: cleared by clr_ovf=1 on a rising edge. If an overflow event and clr_ovf occur in the same cycle, set wins.
- Reset mid-operation: queued entries are lost. If a key is still held after reset release, exactly one event is produced after the normal latency, because stable restarts at 0.

Test Plan:
- Reset, then GS=1, L=7 held steady -> key_valid rises after edge 8, key_code=7, fifo_count=1; with key_ready=1, key_valid=0 one cycle later.
- GS/L toggle between {1,3} and {0,0} every 2 cycles for 20 cycles, then {0,0} -> no push, key_valid stays 0.
- Press 5; while held, L changes to 9 with GS=1; then release -> exactly one entry (5); press 9 after release -> second entry 9.
- key_ready=0, five separate presses 1,2,3,4,6 -> fifo_count=4, overflow=1; drain yields 1,2,3,4 in order; clr_ovf pulse -> overflow=0.
- FIFO full with key_ready=1 on the same cycle a press event occurs -> head popped, new digit appended, fifo_count stays 4, overflow stays 0.
- rst_n pulsed low for 1 cycle while 2 entries are queued and key 8 is held -> all outputs 0 immediately; after release, a single entry 8 appears after edge 8.

Source files
------------

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - debounced key press events queued in a FWFT FIFO
// Synchronises {GS,L}, debounces it, emits one event per press and queues the digit.
module key_event_fifo #(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    L,
    input  logic          GS,
    input  logic          key_ready,
    input  logic          clr_ovf,
    output logic          key_valid,
    output logic [3:0]    key_code,
    output logic [AW:0]   fifo_count,
    output logic          overflow
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEB_CYCLES);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, HELD} state_t;

    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    stable_q, stable_d;
    state_t        state_q, state_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          stable_gs;
    logic [3:0]    stable_code;
    logic          press_event;
    logic          push_req, push_ok, pop, full, ovf_set;

    // Two-flop synchroniser for the asynchronous encoder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {GS, L};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = cand_q;
            cnt_d    = CNT_SAT;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_gs   = stable_q[4];
    assign stable_code = stable_q[3:0];

    // A code change while still held (second key) is deliberately not an event
    always_comb begin
        state_d     = state_q;
        press_event = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_gs) begin
                    press_event = 1'b1;
                    state_d     = HELD;
                end
            end
            HELD: begin
                if (!stable_gs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign full     = (count_q == DEPTH);
    assign pop      = key_valid && key_ready;
    assign push_req = press_event && (stable_code <= 4'd9);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Set has priority over clear so a drop is never silently lost
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= stable_code;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_valid  = (count_q != '0);
    assign key_code   = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule
